// File: rtl/ext_pkg.sv
// ext_pkg: shared types for the immediate-extension pipeline.
//   ext_mode_e   : run-time extension mode carried with each field.
//   pipe_state_e : 2-bit occupancy state (EMPTY/ONE/TWO), also used by
//                  other registered pipeline stages.
package ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_HIGH = 2'b10,
    EXT_BIT  = 2'b11
  } ext_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } pipe_state_e;

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational IN_W -> OUT_W field extender.
// Ports:
//   in_data  [IN_W-1:0]  field to extend
//   in_mode  [1:0]       ZERO / SIGN / HIGH / BIT
//   ext_data [OUT_W-1:0] extended result
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] ext_data
);

  always_comb begin
    ext_data = '0;
    case (ext_mode_e'(in_mode))
      EXT_ZERO: ext_data = OUT_W'(in_data);
      EXT_SIGN: ext_data = OUT_W'($signed(in_data));
      // Shift by zero when IN_W == OUT_W, so the field passes through.
      EXT_HIGH: ext_data = OUT_W'(in_data) << (OUT_W - IN_W);
      EXT_BIT:  ext_data = OUT_W'(in_data[0]);
      default:  ext_data = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate/flag extender with valid/ready
// handshake and a two-entry skid buffer (output register + skid register).
// Ports:
//   clk, reset (async, active-high)
//   in_valid / in_ready / in_data[IN_W-1:0] / in_mode[1:0] : producer side
//   out_valid / out_ready / out_data[OUT_W-1:0]             : consumer side
//   level[1:0] : number of entries held (0..2)
module imm_extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       level
);

  pipe_state_e      state;
  logic [OUT_W-1:0] ext_data;
  logic [OUT_W-1:0] out_reg;
  logic [OUT_W-1:0] skid_reg;
  logic             in_xfer;
  logic             out_xfer;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data  (in_data),
    .in_mode  (in_mode),
    .ext_data (ext_data)
  );

  // Handshake outputs are pure decodes of the state register, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign level     = state;
  assign out_data  = out_reg;

  assign in_xfer  = in_valid  & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      out_reg  <= '0;
      skid_reg <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_reg <= ext_data;
            state   <= ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              skid_reg <= ext_data;
              state    <= TWO;
            end
            2'b01: state <= EMPTY;
            2'b11: out_reg <= ext_data;
            default: ;
          endcase
        end
        TWO: begin
          if (out_xfer) begin
            out_reg <= skid_reg;
            state   <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic        clk = 0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [31:0] out_data;
  logic [1:0]  level;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] in_data8, out_data8;
  logic [1:0] in_mode8, level8;

  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .level(level)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_mode(in_mode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .level(level8)
  );

  // Extension rules as plain arithmetic on unsigned integers.
  function automatic longint unsigned ref_ext(longint unsigned d, int m, int iw, int ow);
    longint unsigned span;
    span = 64'd1 << iw;
    d = d % span;
    case (m)
      0: return d;
      1: return (d >= span / 2) ? d + ((64'd1 << ow) - span) : d;
      2: return d * (64'd1 << (ow - iw));
      default: return d % 2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the 16->32 DUT against the 2-deep FIFO model.
  task automatic check_model(input string tag);
    chk({tag, ".level"}, 64'(level), 64'(q.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) chk({tag, ".out_data"}, 64'(out_data), 64'(q[0]));
  endtask

  // One clock cycle: drive, check before the edge, update model at the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic [1:0] m,
                      input logic ordy, input string tag);
    bit ix, ox;
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy;
    @(negedge clk);
    check_model(tag);
    ix = v && (q.size() < 2);
    ox = (q.size() > 0) && ordy;
    @(posedge clk);
    if (ox) void'(q.pop_front());
    if (ix) q.push_back(32'(ref_ext(64'(d), int'(m), 16, 32)));
    #1;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = '0; in_mode = '0; out_ready = 0;
    in_valid8 = 0; in_data8 = '0; in_mode8 = '0; out_ready8 = 1;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data", 64'(out_data), 64'd0);
    chk("rst.level", 64'(level), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rel.in_ready", 64'(in_ready), 64'd1);

    // Sign extension then back-to-back modes at full throughput.
    step(1, 16'h8001, 2'b01, 1, "sign");
    chk("sign.const", 64'(out_data), 64'hFFFF8001);
    chk("sign.level1", 64'(level), 64'd1);
    step(1, 16'h8001, 2'b00, 1, "zero");
    chk("zero.const", 64'(out_data), 64'h00008001);
    step(1, 16'h8001, 2'b10, 1, "high");
    chk("high.const", 64'(out_data), 64'h80010000);
    step(1, 16'h8001, 2'b11, 1, "bit");
    chk("bit.const", 64'(out_data), 64'h00000001);
    step(0, 16'h0, 2'b00, 1, "drain");
    chk("drain.level0", 64'(level), 64'd0);

    // Back-pressure: two accepted, third blocked, then drained in order.
    step(1, 16'h1234, 2'b01, 0, "bp1");
    step(1, 16'hF00F, 2'b01, 0, "bp2");
    chk("bp.level2", 64'(level), 64'd2);
    chk("bp.in_ready0", 64'(in_ready), 64'd0);
    chk("bp.head", 64'(out_data), 64'h00001234);
    step(1, 16'hABCD, 2'b00, 0, "bp3");
    step(1, 16'hABCD, 2'b00, 1, "bp4");
    chk("bp.second", 64'(out_data), 64'hFFFFF00F);
    step(1, 16'hABCD, 2'b00, 1, "bp5");
    chk("bp.third", 64'(out_data), 64'h0000ABCD);
    step(0, 16'h0, 2'b00, 1, "bp6");

    // Simultaneous in/out transfer while holding one entry.
    step(1, 16'h0007, 2'b10, 0, "sim1");
    step(1, 16'h7FFF, 2'b01, 1, "sim2");
    chk("sim.level1", 64'(level), 64'd1);
    chk("sim.data", 64'(out_data), 64'h00007FFF);
    step(0, 16'h0, 2'b00, 1, "sim3");

    // Asynchronous reset while full.
    step(1, 16'h1111, 2'b00, 0, "ar1");
    step(1, 16'h2222, 2'b00, 0, "ar2");
    chk("ar.full", 64'(level), 64'd2);
    reset = 1;
    #1;
    chk("ar.out_valid", 64'(out_valid), 64'd0);
    chk("ar.out_data", 64'(out_data), 64'd0);
    chk("ar.level", 64'(level), 64'd0);
    chk("ar.in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #1 reset = 0;
    step(1, 16'h00FF, 2'b01, 1, "ar.first");
    chk("ar.first_acc", 64'(out_data), 64'h000000FF);

    // Randomized traffic against the FIFO model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
           1'($urandom_range(0, 2) != 0), "rnd");
    end
    for (int i = 0; i < 4; i++) step(0, 16'h0, 2'b00, 1, "flush");

    // IN_W == OUT_W == 8 instance.
    in_valid8 = 1; in_data8 = 8'h80; in_mode8 = 2'b01;
    @(posedge clk); #1;
    chk("w8.sign", 64'(out_data8), 64'h80);
    in_data8 = 8'h5A; in_mode8 = 2'b10;
    @(posedge clk); #1;
    chk("w8.high", 64'(out_data8), 64'h5A);
    in_data8 = 8'hFE; in_mode8 = 2'b11;
    @(posedge clk); #1;
    chk("w8.bit", 64'(out_data8), 64'h00);
    chk("w8.valid", 64'(out_valid8), 64'd1);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic [1:0] m;
      d = 8'($urandom); m = 2'($urandom);
      in_data8 = d; in_mode8 = m;
      @(posedge clk); #1;
      chk("w8.rnd", 64'(out_data8), ref_ext(64'(d), int'(m), 8, 8));
    end
    in_valid8 = 0;
    @(posedge clk); #1;
    chk("w8.empty", 64'(out_valid8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
